// File: rtl/serialdump_pkg.sv
// serialdump shared types: FSM states and register offsets.
// Optional checksum trailer is enabled with SERIALDUMP_CKSUM_EN.
package serialdump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_FIN   = 3'd4
  } sd_state_e;

  localparam logic [2:0] SD_START = 3'd0;
  localparam logic [2:0] SD_LEN   = 3'd1;
  localparam logic [2:0] SD_CTRL  = 3'd2;
  localparam logic [2:0] SD_CKSUM = 3'd3;

  function automatic logic [7:0] sd_byte(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    return w[8*i +: 8];
  endfunction

endpackage

// File: rtl/serialdump_txser.sv
// serialdump word-to-byte serializer, little-endian byte order.
// A load wins over a handshake so back-to-back words do not bubble.
module serialdump_txser
  import serialdump_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        hs;

  assign hs = valid_q & tx_ready_i;

  // next word/byte index/valid
  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (hs) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) valid_d = 1'b0;
    end
  end

  // serializer state
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data_o  = sd_byte(word_q, idx_q);
  assign tx_valid_o = valid_q;
  assign last_o     = (idx_q == 2'd3);

endmodule

// File: rtl/serialdump.sv
// serialdump: streams a memory range to the UART tx path.
// Define SERIALDUMP_CKSUM_EN for the checksum trailer and CKSUM register.
module serialdump
  import serialdump_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  input  logic [31:0] a_cpu,
  input  logic [31:0] d_cpu,
  input  logic        we_cpu,
  input  logic        rd_cpu,
  output logic [31:0] spo_cpu,
  output logic        ready_cpu,
  output logic [31:0] a_mem,
  output logic [31:0] d_mem,
  output logic        we_mem,
  output logic        rd_mem,
  input  logic [31:0] spo_mem,
  input  logic        ready_mem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

`ifdef SERIALDUMP_CKSUM_EN
  localparam sd_state_e TAIL_ST = ST_TRAIL;
`else
  localparam sd_state_e TAIL_ST = ST_FIN;
`endif

  sd_state_e   state_q, state_d;
  logic [31:0] start_q, start_d;
  logic [31:0] len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        irq_q, irq_d;
  logic        busy;
  logic        start_cmd;
  logic        ser_load;
  logic [31:0] ser_word;
  logic        ser_last;
  logic        ser_hs;
  logic        word_done;
  logic [31:0] sum_rd;

  assign busy      = (state_q != ST_IDLE);
  assign start_cmd = we & (a == SD_CTRL) & d[0] & ~busy;
  assign ser_hs    = tx_valid & tx_ready;
  assign word_done = (state_q == ST_SEND) & ser_hs & ser_last;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start_cmd)
          state_d = (len_q == '0) ? TAIL_ST : ST_FETCH;
      ST_FETCH:
        if (ready_mem) state_d = ST_SEND;
      ST_SEND:
        if (word_done)
          state_d = (cnt_q == 32'd1) ? TAIL_ST : ST_FETCH;
      ST_TRAIL:
        if (ser_hs && ser_last) state_d = ST_FIN;
      ST_FIN:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // programmed registers, working pointer/count, status
  always_comb begin
    start_d = start_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    irq_d   = (state_q == ST_FIN);
    if (we && a == SD_START) start_d = {d[31:2], 2'b00};
    if (we && a == SD_LEN)   len_d   = d;
    if (start_cmd) begin
      addr_d = start_q;
      cnt_d  = len_q;
      done_d = 1'b0;
    end
    if (word_done) begin
      addr_d = addr_q + 32'd4;
      cnt_d  = cnt_q - 32'd1;
    end
    if (state_q == ST_FIN) done_d = 1'b1;
  end

  // register storage
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

`ifdef SERIALDUMP_CKSUM_EN
  logic [31:0] sum_q, sum_d;

  // running checksum of fetched words
  always_comb begin
    sum_d = sum_q;
    if (start_cmd) sum_d = '0;
    else if (state_q == ST_FETCH && ready_mem)
      sum_d = sum_q + spo_mem;
  end

  // checksum storage
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_rd = sum_q;
`else
  assign sum_rd = '0;
`endif

  // memory port ownership, pass-through and serializer feed
  always_comb begin
    a_mem     = a_cpu;
    d_mem     = d_cpu;
    we_mem    = we_cpu;
    rd_mem    = rd_cpu;
    ready_cpu = ready_mem;
    spo_cpu   = spo_mem;
    ser_load  = 1'b0;
    ser_word  = spo_mem;
    if (busy) begin
      a_mem     = addr_q;
      d_mem     = '0;
      we_mem    = 1'b0;
      rd_mem    = (state_q == ST_FETCH);
      ready_cpu = 1'b0;
    end
    if (state_q == ST_FETCH && ready_mem) ser_load = 1'b1;
`ifdef SERIALDUMP_CKSUM_EN
    if (start_cmd && len_q == '0) begin
      ser_load = 1'b1;
      ser_word = '0;
    end
    if (word_done && cnt_q == 32'd1) begin
      ser_load = 1'b1;
      ser_word = sum_rd;
    end
`endif
  end

  // register read mux
  always_comb begin
    case (a)
      SD_START: spo = start_q;
      SD_LEN:   spo = len_q;
      SD_CTRL:  spo = {30'd0, done_q, busy};
      SD_CKSUM: spo = sum_rd;
      default:  spo = '0;
    endcase
  end

  assign irq = irq_q;

  serialdump_txser u_txser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .word_i     (ser_word),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .last_o     (ser_last)
  );

endmodule

// File: tb/tb_serialdump.sv
// serialdump bench: random dumps against a queue-based byte model.
// Honours SERIALDUMP_CKSUM_EN the same way as the design.
module tb_serialdump;
  import serialdump_pkg::*;

  logic        clk = 0;
  logic        rst = 1;
  logic [2:0]  a = '0;
  logic [31:0] d = '0;
  logic        we = 0;
  logic [31:0] spo;
  logic [31:0] a_cpu = '0, d_cpu = '0;
  logic        we_cpu = 0, rd_cpu = 0;
  logic [31:0] spo_cpu;
  logic        ready_cpu;
  logic [31:0] a_mem, d_mem;
  logic        we_mem, rd_mem;
  logic [31:0] spo_mem;
  logic        ready_mem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1;
  logic        irq;

  int tests = 0;
  int fails = 0;
  int lat = 0;
  int mode_r = 0;
  int wcnt = 0;
  int cyc = 0;
  int irq_cnt = 0;
  logic [7:0]  got[$];
  logic [31:0] rda[$];
  logic        prev_v = 0, prev_r = 0, prev_rst = 1;
  logic [7:0]  prev_d = '0;

  serialdump dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo),
    .a_cpu(a_cpu), .d_cpu(d_cpu), .we_cpu(we_cpu), .rd_cpu(rd_cpu),
    .spo_cpu(spo_cpu), .ready_cpu(ready_cpu),
    .a_mem(a_mem), .d_mem(d_mem), .we_mem(we_mem), .rd_mem(rd_mem),
    .spo_mem(spo_mem), .ready_mem(ready_mem),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] ad);
    if (ad == 32'h100) return 32'h11223344;
    if (ad == 32'h104) return 32'hAABBCCDD;
    return (ad * 32'h9E3779B1) + 32'h7F4A7C15;
  endfunction

  assign spo_mem   = memval(a_mem);
  assign ready_mem = rd_mem && (wcnt >= lat);

  always @(posedge clk) begin
    if (!rd_mem || ready_mem) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (mode_r)
        0: tx_ready = 1'b1;
        1: tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) got.push_back(tx_data);
    if (!rst && rd_mem && ready_mem && !ready_cpu) rda.push_back(a_mem);
    if (irq) irq_cnt++;
    if (!rst && !prev_rst && prev_v && !prev_r) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_data", 32'(tx_data), 32'(prev_d));
    end
    if (!rst && a == SD_CTRL && spo[0]) begin
      if (ready_cpu !== 1'b0 || we_mem !== 1'b0) begin
        chk("busy_ready_cpu", 32'(ready_cpu), 32'd0);
        chk("busy_we_mem", 32'(we_mem), 32'd0);
      end
    end
    prev_v = tx_valid;
    prev_r = tx_ready;
    prev_d = tx_data;
    prev_rst = rst;
  end

  task automatic write_reg(input logic [2:0] ra, input logic [31:0] rv);
    @(posedge clk);
    #1;
    a = ra;
    d = rv;
    we = 1;
    @(posedge clk);
    #1;
    we = 0;
  endtask

  task automatic run_dump(input logic [31:0] st, input logic [31:0] len,
                          input int mode, input bit cpurd,
                          input bit busywr);
    logic [7:0]  exq[$];
    logic [31:0] rdx[$];
    logic [31:0] s, ad, w, ca;
    int k, n0;
    s = '0;
    ad = st & ~32'd3;
    for (int i = 0; i < int'(len); i++) begin
      w = memval(ad);
      rdx.push_back(ad);
      for (int b = 0; b < 4; b++) exq.push_back(w[8*b +: 8]);
      s += w;
      ad += 32'd4;
    end
`ifdef SERIALDUMP_CKSUM_EN
    for (int b = 0; b < 4; b++) exq.push_back(s[8*b +: 8]);
`else
    s = '0;
`endif
    mode_r = mode;
    lat = $urandom_range(0, 3);
    write_reg(SD_START, st);
    write_reg(SD_LEN, len);
    got.delete();
    rda.delete();
    n0 = irq_cnt;
    write_reg(SD_CTRL, 32'd1);
    chk("start_busy", spo, 32'd1);
    chk("start_rd_mem", 32'(rd_mem), 32'(len != 0));
    if (busywr) begin
      write_reg(SD_LEN, 32'd7);
      write_reg(SD_CTRL, 32'd1);
      a = SD_CTRL;
      d = '0;
    end
    ca = $urandom & ~32'd3;
    if (cpurd) begin
      a_cpu = ca;
      rd_cpu = 1;
    end
    k = 0;
    while (!irq && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("irq_seen", 32'(irq), 32'd1);
    chk("done_stat", spo, 32'd2);
    @(negedge clk);
    chk("irq_one_cycle", 32'(irq), 32'd0);
    chk("irq_count", 32'(irq_cnt - n0), 32'd1);
    if (cpurd) begin
      k = 0;
      while (!ready_cpu && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("cpu_ready", 32'(ready_cpu), 32'd1);
      chk("cpu_data", spo_cpu, memval(ca));
      @(posedge clk);
      #1;
      rd_cpu = 0;
    end
    chk("byte_count", 32'(got.size()), 32'(exq.size()));
    for (int i = 0; i < exq.size() && i < got.size(); i++)
      chk("byte", 32'(got[i]), 32'(exq[i]));
    chk("read_count", 32'(rda.size()), 32'(rdx.size()));
    for (int i = 0; i < rdx.size() && i < rda.size(); i++)
      chk("read_addr", rda[i], rdx[i]);
    a = SD_CKSUM;
    #1;
    chk("cksum_reg", spo, s);
    a = SD_CTRL;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rd_mem", 32'(rd_mem), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    for (int r = 0; r < 4; r++) begin
      a = 3'(r);
      #1;
      chk("rst_reg", spo, 32'd0);
    end
    rst = 0;
    a_cpu = 32'h55;
    d_cpu = 32'hCAFE0001;
    we_cpu = 1;
    #1;
    chk("pt_we", 32'(we_mem), 32'd1);
    chk("pt_addr", a_mem, 32'h55);
    chk("pt_data", d_mem, 32'hCAFE0001);
    we_cpu = 0;
    write_reg(SD_START, 32'h103);
    a = SD_START;
    #1;
    chk("start_mask", spo, 32'h100);

    run_dump(32'h100, 32'd2, 0, 0, 0);
    run_dump(32'h100, 32'd2, 1, 0, 1);
    run_dump(32'h200, 32'd0, 0, 0, 0);
    run_dump(32'h300, 32'd3, 2, 1, 0);
    run_dump(32'hFFFFFFFC, 32'd2, 0, 0, 0);
    for (int t = 0; t < 4; t++)
      run_dump($urandom, 32'($urandom_range(1, 5)), 2, 0, 0);

    mode_r = 0;
    write_reg(SD_START, 32'h100);
    write_reg(SD_LEN, 32'd2);
    write_reg(SD_CTRL, 32'd1);
    k = 0;
    while (!(tx_valid && tx_data == 8'h22) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_byte2", 32'(tx_data), 32'h22);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_rd_mem", 32'(rd_mem), 32'd0);
    a = SD_CTRL;
    #1;
    chk("mid_rst_stat", spo, 32'd0);
    a = SD_LEN;
    #1;
    chk("mid_rst_len", spo, 32'd0);
    a = SD_START;
    #1;
    chk("mid_rst_start", spo, 32'd0);
    run_dump(32'h100, 32'd2, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
